// File: rtl/clock_reset_ctrl.sv
// Clock-generator reset/lock sequencer with ordered per-domain reset release (AXI, ETH, core).
// All outputs registered, one edge after the deciding condition; no backpressure, inputs sampled every cycle.
module clock_reset_ctrl #(
   parameter int RST_PULSE     = 16,
   parameter int STABLE_CYCLES = 256,
   parameter int LOCK_TIMEOUT  = 65535,
   parameter int STAGE_GAP     = 8,
   parameter int MAX_RETRY     = 3,
   parameter int CNT_W         = 16
) (
   input  logic       clk,
   input  logic       g_reset_n,
   input  logic       dcm_locked,
   input  logic       soft_reset_req,
   output logic       dcm_reset,
   output logic       axi_rst_n,
   output logic       eth_rst_n,
   output logic       core_rst_n,
   output logic       ready,
   output logic       fail,
   output logic [7:0] relock_cnt
);

   localparam logic [2:0] S_DCM_RST   = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_REL_AXI   = 3'd2;
   localparam logic [2:0] S_REL_ETH   = 3'd3;
   localparam logic [2:0] S_RUN       = 3'd4;
   localparam logic [2:0] S_FAIL      = 3'd5;

   localparam int RTY_W = $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0] PULSE_N   = CNT_W'(RST_PULSE);
   localparam logic [CNT_W-1:0] STABLE_N  = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] TIMEOUT_N = CNT_W'(LOCK_TIMEOUT);
   localparam logic [CNT_W-1:0] GAP_N     = CNT_W'(STAGE_GAP);
   localparam logic [RTY_W-1:0] RETRY_N   = RTY_W'(MAX_RETRY);

   logic             lock_m;
   logic             lock_s;
   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] stab;
   logic [CNT_W-1:0] stab_nxt;
   logic [RTY_W-1:0] retry;
   logic [RTY_W-1:0] retry_nxt;
   logic [7:0]       relock_nxt;

   always_ff @(posedge clk or negedge g_reset_n) begin
      if (!g_reset_n) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= dcm_locked;
         lock_s <= lock_m;
      end
   end

   assign cnt_inc = cnt + CNT_W'(1);

   // In DCM_RST, cnt is the number of pulse cycles already served: the entering
   // edge counts as the first, whereas release from g_reset_n counts as none.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      stab_nxt   = '0;
      retry_nxt  = retry;
      relock_nxt = relock_cnt;
      if (soft_reset_req) begin
         state_nxt = S_DCM_RST;
         cnt_nxt   = CNT_W'(1);
         retry_nxt = '0;
      end else begin
         case (state)
            S_DCM_RST: begin
               if (cnt == PULSE_N) begin
                  state_nxt = S_WAIT_LOCK;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            S_WAIT_LOCK: begin
               cnt_nxt  = cnt_inc;
               stab_nxt = lock_s ? stab + CNT_W'(1) : '0;
               if (stab_nxt == STABLE_N) begin
                  state_nxt = S_REL_AXI;
                  cnt_nxt   = '0;
                  stab_nxt  = '0;
               end else if (cnt_inc == TIMEOUT_N) begin
                  retry_nxt = retry + RTY_W'(1);
                  stab_nxt  = '0;
                  if (retry_nxt == RETRY_N) begin
                     state_nxt = S_FAIL;
                     cnt_nxt   = '0;
                  end else begin
                     state_nxt = S_DCM_RST;
                     cnt_nxt   = CNT_W'(1);
                  end
               end
            end
            S_REL_AXI, S_REL_ETH, S_RUN: begin
               if (!lock_s) begin
                  state_nxt  = S_DCM_RST;
                  cnt_nxt    = CNT_W'(1);
                  relock_nxt = (relock_cnt == 8'hFF) ? relock_cnt : relock_cnt + 8'd1;
               end else if (state != S_RUN) begin
                  if (cnt_inc == GAP_N) begin
                     state_nxt = (state == S_REL_AXI) ? S_REL_ETH : S_RUN;
                     cnt_nxt   = '0;
                     if (state == S_REL_ETH) retry_nxt = '0;
                  end else begin
                     cnt_nxt = cnt_inc;
                  end
               end
            end
            S_FAIL: begin
               state_nxt = S_FAIL;
            end
            default: begin
               state_nxt = S_DCM_RST;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Outputs decode the next state so they change on the same edge as the state.
   always_ff @(posedge clk or negedge g_reset_n) begin
      if (!g_reset_n) begin
         state      <= S_DCM_RST;
         cnt        <= '0;
         stab       <= '0;
         retry      <= '0;
         relock_cnt <= '0;
         dcm_reset  <= 1'b1;
         axi_rst_n  <= 1'b0;
         eth_rst_n  <= 1'b0;
         core_rst_n <= 1'b0;
         ready      <= 1'b0;
         fail       <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         stab       <= stab_nxt;
         retry      <= retry_nxt;
         relock_cnt <= relock_nxt;
         dcm_reset  <= (state_nxt == S_DCM_RST);
         axi_rst_n  <= (state_nxt == S_REL_AXI) || (state_nxt == S_REL_ETH) || (state_nxt == S_RUN);
         eth_rst_n  <= (state_nxt == S_REL_ETH) || (state_nxt == S_RUN);
         core_rst_n <= (state_nxt == S_RUN);
         ready      <= (state_nxt == S_RUN);
         fail       <= (state_nxt == S_FAIL);
      end
   end

endmodule

// File: tb/tb_clock_reset_ctrl.sv
// Directed and randomized bench for clock_reset_ctrl against a phase/age reference model.
module tb_clock_reset_ctrl;

   localparam int RP = 4;
   localparam int SC = 8;
   localparam int LT = 32;
   localparam int SG = 2;
   localparam int MR = 2;

   logic       clk = 1'b0;
   logic       g_reset_n = 1'b1;
   logic       dcm_locked = 1'b0;
   logic       soft_reset_req = 1'b0;
   logic       dcm_reset;
   logic       axi_rst_n;
   logic       eth_rst_n;
   logic       core_rst_n;
   logic       ready;
   logic       fail;
   logic [7:0] relock_cnt;

   clock_reset_ctrl #(
      .RST_PULSE(RP), .STABLE_CYCLES(SC), .LOCK_TIMEOUT(LT),
      .STAGE_GAP(SG), .MAX_RETRY(MR), .CNT_W(16)
   ) dut (
      .clk(clk), .g_reset_n(g_reset_n), .dcm_locked(dcm_locked),
      .soft_reset_req(soft_reset_req), .dcm_reset(dcm_reset),
      .axi_rst_n(axi_rst_n), .eth_rst_n(eth_rst_n), .core_rst_n(core_rst_n),
      .ready(ready), .fail(fail), .relock_cnt(relock_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int ecnt  = 0;

   // Reference model: phase plus edges elapsed since the phase began.
   typedef enum int {M_RST, M_WAIT, M_AXI, M_ETH, M_RUN, M_FAIL} mph_t;
   mph_t m_ph;
   int   m_age, m_stab, m_retry, m_relock;
   bit   m_hist [2];

   int t_dcm_fall, t_dcm_fall_last, n_dcm_fall, n_dcm_rise;
   int t_axi, t_axi_fall, t_eth, t_core, t_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, ecnt, obs, exp);
      end
   endtask

   function automatic void m_enter(input mph_t p);
      m_ph   = p;
      m_age  = 0;
      m_stab = 0;
   endfunction

   function automatic void model_init();
      m_ph      = M_RST;
      m_age     = -1;
      m_stab    = 0;
      m_retry   = 0;
      m_relock  = 0;
      m_hist[0] = 1'b0;
      m_hist[1] = 1'b0;
   endfunction

   function automatic void model_step(input bit lk, input bit srq);
      bit ls;
      ls        = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = lk;
      m_age++;
      if (srq) begin
         m_enter(M_RST);
         m_retry = 0;
      end else begin
         case (m_ph)
            M_RST:  if (m_age == RP) m_enter(M_WAIT);
            M_WAIT: begin
               m_stab = ls ? m_stab + 1 : 0;
               if (m_stab == SC) m_enter(M_AXI);
               else if (m_age == LT) begin
                  m_retry++;
                  m_enter((m_retry == MR) ? M_FAIL : M_RST);
               end
            end
            M_AXI, M_ETH, M_RUN: begin
               if (!ls) begin
                  if (m_relock < 255) m_relock++;
                  m_enter(M_RST);
               end else if (m_ph == M_AXI && m_age == SG) m_enter(M_ETH);
               else if (m_ph == M_ETH && m_age == SG) m_enter(M_RUN);
            end
            default: ;
         endcase
      end
      if (m_ph == M_RUN) m_retry = 0;
   endfunction

   function automatic void clear_marks();
      t_dcm_fall = -1; t_dcm_fall_last = -1; n_dcm_fall = 0; n_dcm_rise = 0;
      t_axi = -1; t_axi_fall = -1; t_eth = -1; t_core = -1; t_fail = -1;
   endfunction

   task automatic chk_outs();
      chk("cyc.dcm_reset",  dcm_reset,  m_ph == M_RST);
      chk("cyc.axi_rst_n",  axi_rst_n,  m_ph == M_AXI || m_ph == M_ETH || m_ph == M_RUN);
      chk("cyc.eth_rst_n",  eth_rst_n,  m_ph == M_ETH || m_ph == M_RUN);
      chk("cyc.core_rst_n", core_rst_n, m_ph == M_RUN);
      chk("cyc.ready",      ready,      m_ph == M_RUN);
      chk("cyc.fail",       fail,       m_ph == M_FAIL);
      chk("cyc.relock_cnt", relock_cnt, m_relock);
   endtask

   task automatic tick(input bit lk, input bit srq);
      logic pd, pa, pe, pc, pf;
      dcm_locked     = lk;
      soft_reset_req = srq;
      pd = dcm_reset; pa = axi_rst_n; pe = eth_rst_n; pc = core_rst_n; pf = fail;
      @(posedge clk);
      model_step(lk, srq);
      #1;
      if (pd && !dcm_reset) begin
         if (t_dcm_fall < 0) t_dcm_fall = ecnt;
         t_dcm_fall_last = ecnt;
         n_dcm_fall++;
      end
      if (!pd && dcm_reset) n_dcm_rise++;
      if (!pa && axi_rst_n && t_axi < 0) t_axi = ecnt;
      if (pa && !axi_rst_n) t_axi_fall = ecnt;
      if (!pe && eth_rst_n && t_eth < 0) t_eth = ecnt;
      if (!pc && core_rst_n && t_core < 0) t_core = ecnt;
      if (!pf && fail && t_fail < 0) t_fail = ecnt;
      chk_outs();
      ecnt++;
   endtask

   // Asserts g_reset_n away from any clock edge, checks the asynchronous reset values,
   // then releases on a falling clock edge so the next rising edge is edge 0.
   task automatic do_reset();
      g_reset_n      = 1'b0;
      dcm_locked     = 1'b0;
      soft_reset_req = 1'b0;
      #2;
      chk("rst.dcm_reset",  dcm_reset,  1'b1);
      chk("rst.axi_rst_n",  axi_rst_n,  1'b0);
      chk("rst.eth_rst_n",  eth_rst_n,  1'b0);
      chk("rst.core_rst_n", core_rst_n, 1'b0);
      chk("rst.ready",      ready,      1'b0);
      chk("rst.fail",       fail,       1'b0);
      chk("rst.relock_cnt", relock_cnt, 8'd0);
      model_init();
      clear_marks();
      ecnt = 0;
      @(negedge clk);
      g_reset_n = 1'b1;
   endtask

   initial begin
      int e0;
      bit lk;
      int len;

      // Clean start with lock held high.
      #1;
      do_reset();
      repeat (20) tick(1'b1, 1'b0);
      chk("clean.dcm_fall_edge", t_dcm_fall, 4);
      chk("clean.axi_rise_edge", t_axi, 12);
      chk("clean.eth_rise_edge", t_eth, 14);
      chk("clean.core_rise_edge", t_core, 16);
      chk("clean.ready", ready, 1'b1);
      chk("clean.relock_cnt", relock_cnt, 8'd0);

      // Lock loss while in RUN, then recovery.
      clear_marks();
      e0 = ecnt;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      repeat (22) tick(1'b1, 1'b0);
      chk("loss.rst_low_edge", t_axi_fall, e0 + 2);
      chk("loss.relock_cnt", relock_cnt, 8'd1);
      chk("loss.dcm_pulses", n_dcm_rise, 1);
      chk("loss.dcm_fall_edge", t_dcm_fall_last, e0 + 6);
      chk("loss.axi_again_edge", t_axi, e0 + 14);
      chk("loss.ready_again", ready, 1'b1);

      // Single-cycle glitch restarts the stability count.
      do_reset();
      for (int i = 0; i < 28; i++) tick(i != 5, 1'b0);
      chk("glitch.axi_rise_edge", t_axi, 15);
      chk("glitch.ready", ready, 1'b1);

      // Lock never arrives: two attempts, then FAIL; soft reset recovers.
      do_reset();
      repeat (75) tick(1'b0, 1'b0);
      chk("nolock.fail_edge", t_fail, 72);
      chk("nolock.dcm_rises", n_dcm_rise, 1);
      chk("nolock.dcm_falls", n_dcm_fall, 2);
      chk("nolock.fail", fail, 1'b1);
      chk("nolock.dcm_reset", dcm_reset, 1'b0);
      chk("nolock.domains", {axi_rst_n, eth_rst_n, core_rst_n}, 3'b000);
      tick(1'b0, 1'b1);
      chk("nolock.soft_fail", fail, 1'b0);
      chk("nolock.soft_dcm", dcm_reset, 1'b1);
      repeat (30) tick(1'b1, 1'b0);
      chk("nolock.recovered", ready, 1'b1);

      // Soft reset coinciding with synchronized lock loss in REL_ETH.
      do_reset();
      for (int i = 0; i < 15; i++) tick(i != 13, 1'b0);
      tick(1'b1, 1'b1);
      chk("softloss.rst_low_edge", t_axi_fall, 15);
      chk("softloss.eth_rst_n", eth_rst_n, 1'b0);
      chk("softloss.relock_cnt", relock_cnt, 8'd0);
      repeat (25) tick(1'b1, 1'b0);
      chk("softloss.ready", ready, 1'b1);

      // Asynchronous reset during REL_AXI, then full replay.
      do_reset();
      repeat (13) tick(1'b1, 1'b0);
      chk("async.in_rel_axi", {axi_rst_n, eth_rst_n}, 2'b10);
      do_reset();
      repeat (20) tick(1'b1, 1'b0);
      chk("async.replay_axi_edge", t_axi, 12);
      chk("async.replay_core_edge", t_core, 16);

      // Repeated lock loss drives relock_cnt into saturation.
      do_reset();
      repeat (14) tick(1'b1, 1'b0);
      repeat (260) begin
         tick(1'b0, 1'b0);
         repeat (14) tick(1'b1, 1'b0);
      end
      chk("sat.relock_cnt", relock_cnt, 8'd255);

      // Randomized lock waveform with occasional soft reset requests.
      do_reset();
      repeat (60) begin
         lk  = ($urandom_range(0, 3) != 0);
         len = $urandom_range(1, 45);
         repeat (len) tick(lk, $urandom_range(0, 79) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clock_reset_ctrl.md
# clock_reset_ctrl

Sequencer for the board clock generator: it pulses the generator's reset and qualifies its `dcm_locked` output, retrying on lock timeout. It then releases per-domain resets in a fixed order: AXI first, then Ethernet, then core/video. It sits beside `clock_gen` in the top level and runs on the free-running system clock, so it never depends on a generated clock. Loss of lock or a software request tears all domains back into reset and restarts the sequence.

## Interface
Parameters:
- `RST_PULSE`, 16: cycles `dcm_reset` is held high per attempt (≥2).
- `STABLE_CYCLES`, 256: consecutive synchronized-lock-high cycles required to accept lock (≥1).
- `LOCK_TIMEOUT`, 65535: cycles allowed in WAIT_LOCK per attempt before a retry (> `STABLE_CYCLES`).
- `STAGE_GAP`, 8: cycles between successive domain reset releases (≥1).
- `MAX_RETRY`, 3: failed lock attempts before entering FAIL (≥1).
- `CNT_W`, 16: width of the internal cycle counters; must hold `LOCK_TIMEOUT`.

Ports:
- `clk`, in, 1: free-running system clock, single clock domain.
- `g_reset_n`, in, 1: asynchronous, active-low reset.
- `dcm_locked`, in, 1: lock from the clock generator; asynchronous, synchronized internally.
- `soft_reset_req`, in, 1: single-cycle request to restart the full sequence.
- `dcm_reset`, out, 1: active-high reset to the clock generator (its `g_reset`).
- `axi_rst_n`, out, 1: active-low reset for the `s_axi_clk` domain.
- `eth_rst_n`, out, 1: active-low reset for the `eth_gtx_clk`/`eth_ref_clk` domains.
- `core_rst_n`, out, 1: active-low reset for core/video logic.
- `ready`, out, 1: high only in RUN.
- `fail`, out, 1: high only in FAIL.
- `relock_cnt`, out, 8: count of lock losses seen after RUN or partial release; saturates at 255.

## Operation
- `dcm_locked` passes through a 2-flop synchronizer to `lock_s`. All decisions use `lock_s`.
- All outputs are registered.
- Reset values: state DCM_RST; `dcm_reset` 1; `axi_rst_n`, `eth_rst_n`, `core_rst_n` 0; `ready` 0; `fail` 0; `relock_cnt` 0; retry and cycle counters 0.

States:
- DCM_RST:
  - `dcm_reset` 1; all domain resets asserted.
  - After `RST_PULSE` cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - `dcm_reset` 0.
  - A stability counter counts consecutive `lock_s`=1 cycles and clears on any 0.
  - When it reaches `STABLE_CYCLES`, go to REL_AXI.
  - A timeout counter runs from entry. If it reaches `LOCK_TIMEOUT` first, retry increments.
  - If retry now equals `MAX_RETRY`, go to FAIL; otherwise go to DCM_RST.
- REL_AXI: `axi_rst_n` goes to 1 on entry. After `STAGE_GAP` cycles, go to REL_ETH.
- REL_ETH: `eth_rst_n` goes to 1 on entry. After `STAGE_GAP` cycles, go to RUN.
- RUN: `core_rst_n` and `ready` go to 1 on entry. Retry clears.
- FAIL:
  - `dcm_reset` 0; all domain resets asserted; `fail` 1.
  - Exit only via `g_reset_n` or `soft_reset_req`.

Lock loss:
- Applies when `lock_s`=0 in REL_AXI, REL_ETH or RUN.
- Next edge: all domain resets go to 0, `ready` 0, state DCM_RST, `relock_cnt` +1 (saturating). Retry is untouched.

Soft reset:
- `soft_reset_req` in any state moves to DCM_RST on the next edge, with all domain resets asserted, retry cleared and cycle counters cleared.
- It has priority over lock loss and timeout in the same cycle. When it coincides with lock loss, `relock_cnt` is not incremented.
- `soft_reset_req` held for several cycles keeps restarting DCM_RST; `dcm_reset` stays high until RST_PULSE cycles after its last assertion.

Invariant: domain resets deassert only in order AXI, then ETH, then core, and reassert together.

## Timing
- Edge numbering: edge 0 is the first rising `clk` after `g_reset_n` deasserts.
- `dcm_reset` is high from reset. It falls on the edge that completes `RST_PULSE` cycles in DCM_RST, which is edge `RST_PULSE` after reset.
- `lock_s` lags `dcm_locked` by 2 edges.
- `axi_rst_n` rises on the edge where the stability count reaches `STABLE_CYCLES`. If `lock_s` is already 1 on WAIT_LOCK entry, that is edge `RST_PULSE`+`STABLE_CYCLES`.
- `eth_rst_n` rises `STAGE_GAP` edges after `axi_rst_n`.
- `core_rst_n` and `ready` rise `STAGE_GAP` edges after `eth_rst_n`.
- Lock loss to all domain resets low: 1 edge after `lock_s` falls, so 3 edges after `dcm_locked` falls.
- Assertion of `g_reset_n` (low) forces all reset values immediately and asynchronously; this includes mid-sequence.

## Test plan
Parameters for all scenarios: `RST_PULSE`=4, `STABLE_CYCLES`=8, `LOCK_TIMEOUT`=32, `STAGE_GAP`=2, `MAX_RETRY`=2.

- Clean start, `dcm_locked` held 1 -> `dcm_reset` falls at edge 4; `axi_rst_n` rises at edge 12; `eth_rst_n` rises at edge 14; `core_rst_n` and `ready` rise at edge 16; `relock_cnt` 0.
- Glitchy lock (1 for 5 cycles, 0 for 1 cycle, then steady 1) -> the stability count restarts; `axi_rst_n` rises 8 edges after steady `lock_s`.
- `dcm_locked` never rises -> two 4-cycle `dcm_reset` pulses with 32-cycle waits between; then `fail`=1, `dcm_reset`=0, all domain resets 0. A following `soft_reset_req` restarts at DCM_RST with `fail`=0.
- In RUN, drop `dcm_locked` -> 3 edges later all three resets are 0, `ready`=0, `relock_cnt`=1, and a new `dcm_reset` pulse of 4 cycles follows. Restore lock -> RUN is reached again.
- `soft_reset_req` in the same cycle `lock_s` falls during REL_ETH -> DCM_RST; `relock_cnt` unchanged; `eth_rst_n` and `axi_rst_n` go to 0 next edge.
- `g_reset_n` pulsed low during REL_AXI -> all outputs return to their reset values asynchronously; the sequence replays from edge 0.
